// File: rtl/spram_bist_pkg.sv
// Shared types and March C- element lookup for the single-port RAM BIST.
package spram_bist_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

    localparam int unsigned ELEM_W = 3;

    localparam logic [ELEM_W-1:0] E0 = 3'd0;
    localparam logic [ELEM_W-1:0] E1 = 3'd1;
    localparam logic [ELEM_W-1:0] E2 = 3'd2;
    localparam logic [ELEM_W-1:0] E3 = 3'd3;
    localparam logic [ELEM_W-1:0] E4 = 3'd4;
    localparam logic [ELEM_W-1:0] E5 = 3'd5;

    // Elements E3/E4 walk the array downwards.
    function automatic logic elem_down(input logic [ELEM_W-1:0] e);
        return (e == E3) || (e == E4);
    endfunction

    // Expected read pattern is all ones for E2/E4, all zeros otherwise.
    function automatic logic elem_read_ones(input logic [ELEM_W-1:0] e);
        return (e == E2) || (e == E4);
    endfunction

    function automatic logic elem_write_ones(input logic [ELEM_W-1:0] e);
        return (e == E1) || (e == E3);
    endfunction

endpackage

// File: rtl/spram_march_bist_if.sv
// Control/status and RAM-side bus of the March BIST engine.
interface spram_march_bist_if
    import spram_bist_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  pass;
    logic [ADDR_WIDTH-1:0] fail_addr;
    logic [ELEM_W-1:0]     fail_elem;
    logic [DATA_WIDTH-1:0] fail_data;
    logic [DATA_WIDTH-1:0] ram_data;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_q;

    modport master (
        input  start, ram_q,
        output busy, done, pass, fail_addr, fail_elem, fail_data,
        output ram_data, ram_addr, ram_we
    );

    modport slave (
        output start, ram_q,
        input  busy, done, pass, fail_addr, fail_elem, fail_data,
        input  ram_data, ram_addr, ram_we
    );
endinterface

// File: rtl/march_addr_gen.sv
// Up/down address counter for the March walk; saturates at the end of the range.
module march_addr_gen #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DEPTH      = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  load_down,
    input  logic                  en,
    input  logic                  down,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last_c
);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    assign last_c = down ? (addr_q == '0) : (addr_q == LAST_ADDR);
    assign addr   = addr_q;

    always_comb begin
        addr_d = addr_q;
        if (load) begin
            addr_d = load_down ? LAST_ADDR : '0;
        end else if (en && !last_c) begin
            addr_d = down ? (addr_q - ADDR_WIDTH'(1)) : (addr_q + ADDR_WIDTH'(1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) addr_q <= '0;
        else     addr_q <= addr_d;
    end
endmodule

// File: rtl/spram_march_bist.sv
// March C- BIST engine driving a single-port RAM; stops on the first mismatch.
module spram_march_bist
    import spram_bist_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 64
) (
    input  logic               clk,
    input  logic               rst,
    spram_march_bist_if.master bus
);
    state_e                state_q, state_d;
    logic [ELEM_W-1:0]     elem_q, elem_d, elem_nxt_c;
    logic                  phase_q, phase_d;
    logic                  cmp_valid_q, cmp_valid_d;
    logic [ADDR_WIDTH-1:0] cmp_addr_q, cmp_addr_d;
    logic [DATA_WIDTH-1:0] cmp_exp_q, cmp_exp_d;
    logic                  busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
    logic [ELEM_W-1:0]     fail_elem_q, fail_elem_d;
    logic [DATA_WIDTH-1:0] fail_data_q, fail_data_d;

    logic                  ag_load, ag_load_down, ag_en, ag_last;
    logic [ADDR_WIDTH-1:0] ag_addr;
    logic                  ram_we_c, mism_c, step_c;
    logic [ADDR_WIDTH-1:0] ram_addr_c;
    logic [DATA_WIDTH-1:0] ram_data_c;

    function automatic logic [DATA_WIDTH-1:0] pat(input logic ones);
        return {DATA_WIDTH{ones}};
    endfunction

    march_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (ag_load),
        .load_down (ag_load_down),
        .en        (ag_en),
        .down      (elem_down(elem_q)),
        .addr      (ag_addr),
        .last_c    (ag_last)
    );

    // RAM controls are combinational so a failing compare can suppress its own write.
    always_comb begin
        state_d      = state_q;
        elem_d       = elem_q;
        elem_nxt_c   = elem_q + ELEM_W'(1);
        phase_d      = phase_q;
        cmp_valid_d  = 1'b0;
        cmp_addr_d   = cmp_addr_q;
        cmp_exp_d    = cmp_exp_q;
        pass_d       = pass_q;
        fail_addr_d  = fail_addr_q;
        fail_elem_d  = fail_elem_q;
        fail_data_d  = fail_data_q;
        ag_load      = 1'b0;
        ag_load_down = 1'b0;
        ag_en        = 1'b0;
        ram_we_c     = 1'b0;
        ram_addr_c   = '0;
        ram_data_c   = '0;
        mism_c       = 1'b0;
        step_c       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d     = RUN;
                    elem_d      = E0;
                    phase_d     = 1'b0;
                    pass_d      = 1'b0;
                    fail_addr_d = '0;
                    fail_elem_d = '0;
                    fail_data_d = '0;
                    ag_load     = 1'b1;
                end
            end
            RUN: begin
                ram_addr_c = ag_addr;
                if (elem_q == E0) begin
                    ram_we_c   = 1'b1;
                    ram_data_c = pat(elem_write_ones(E0));
                    step_c     = 1'b1;
                end else if (elem_q == E5) begin
                    // Read-only element: compare the previous read while issuing the next.
                    cmp_valid_d = 1'b1;
                    cmp_addr_d  = ag_addr;
                    cmp_exp_d   = pat(elem_read_ones(E5));
                    step_c      = 1'b1;
                    if (cmp_valid_q && (bus.ram_q != cmp_exp_q)) begin
                        mism_c      = 1'b1;
                        fail_addr_d = cmp_addr_q;
                    end
                end else if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d    = 1'b0;
                    ram_data_c = pat(elem_write_ones(elem_q));
                    if (bus.ram_q != pat(elem_read_ones(elem_q))) begin
                        mism_c      = 1'b1;
                        fail_addr_d = ag_addr;
                    end else begin
                        ram_we_c = 1'b1;
                        step_c   = 1'b1;
                    end
                end

                if (mism_c) begin
                    state_d     = DONE;
                    fail_elem_d = elem_q;
                    fail_data_d = bus.ram_q;
                end else if (step_c) begin
                    if (!ag_last) begin
                        ag_en = 1'b1;
                    end else if (elem_q == E5) begin
                        state_d = DRAIN;
                    end else begin
                        elem_d       = elem_nxt_c;
                        ag_load      = 1'b1;
                        ag_load_down = elem_down(elem_nxt_c);
                    end
                end
            end
            DRAIN: begin
                state_d = DONE;
                if (bus.ram_q != cmp_exp_q) begin
                    fail_addr_d = cmp_addr_q;
                    fail_elem_d = E5;
                    fail_data_d = bus.ram_q;
                end else begin
                    pass_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN) || (state_d == DRAIN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            elem_q      <= '0;
            phase_q     <= 1'b0;
            cmp_valid_q <= 1'b0;
            cmp_addr_q  <= '0;
            cmp_exp_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
            fail_data_q <= '0;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            phase_q     <= phase_d;
            cmp_valid_q <= cmp_valid_d;
            cmp_addr_q  <= cmp_addr_d;
            cmp_exp_q   <= cmp_exp_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_addr_q <= fail_addr_d;
            fail_elem_q <= fail_elem_d;
            fail_data_q <= fail_data_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.fail_addr = fail_addr_q;
    assign bus.fail_elem = fail_elem_q;
    assign bus.fail_data = fail_data_q;
    assign bus.ram_we    = ram_we_c;
    assign bus.ram_addr  = ram_addr_c;
    assign bus.ram_data  = ram_data_c;
endmodule

// File: tb/tb_spram_march_bist.sv
// Bench for spram_march_bist: fault-injecting RAM model plus an array-level March C- reference.
module tb_spram_march_bist;
    localparam int unsigned AW  = 8;
    localparam int unsigned DW  = 8;
    localparam int unsigned DEP = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spram_march_bist_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    spram_march_bist_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

    spram_march_bist #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEP)) dut (
        .clk (clk), .rst (rst), .bus (bus)
    );
    spram_march_bist #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(1)) dut1 (
        .clk (clk), .rst (rst), .bus (bus1)
    );

    // Fault kinds: 0 none, 1 stuck-at-0, 2 stuck-at-1, 3 write to f_addr flips f_vic bits.
    int         f_kind, f_addr, f_vic;
    logic [7:0] f_mask;
    logic [7:0] mem      [DEP];
    logic [7:0] mem_init [DEP];
    logic       init_req = 1'b0;
    logic [7:0] mem1;
    int         total = 0;
    int         bad   = 0;

    typedef struct {
        int         kind;
        int         faddr;
        int         fvic;
        logic [7:0] mask;
        logic       exp_pass;
        logic [2:0] exp_elem;
        logic [7:0] exp_addr;
        logic [7:0] exp_data;
        int         exp_done;
    } vec_t;
    vec_t vecs [4];

    function automatic logic [7:0] fault_rd(input logic [7:0] s, input int a);
        if (a == f_addr && f_kind == 1) return s & ~f_mask;
        if (a == f_addr && f_kind == 2) return s | f_mask;
        return s;
    endfunction

    always @(posedge clk) begin
        if (init_req) begin
            for (int i = 0; i < int'(DEP); i++) mem[i] <= mem_init[i];
        end else if (bus.ram_we) begin
            mem[bus.ram_addr[5:0]] <= bus.ram_data;
            if (f_kind == 3 && int'(bus.ram_addr) == f_addr) mem[f_vic] <= mem[f_vic] ^ f_mask;
        end else begin
            bus.ram_q <= fault_rd(mem[bus.ram_addr[5:0]], int'(bus.ram_addr));
        end
    end

    always @(posedge clk) begin
        if (bus1.ram_we) mem1 <= bus1.ram_data;
        else             bus1.ram_q <= mem1;
    end

    // Walks March C- over a plain array; done cycle = cycle of the failing (or last) read + 2.
    function automatic void ref_march(output logic p, output logic [2:0] fe, output logic [7:0] fa,
                                      output logic [7:0] fd, output int dc);
        logic [7:0] m [DEP];
        logic [7:0] v, ev, wv;
        int n, a;
        bit dn;
        m = mem_init;
        n = 0; p = 1'b1; fe = '0; fa = '0; fd = '0; dc = 10 * int'(DEP) + 2;
        for (int e = 0; e < 6; e++) begin
            dn = (e == 3 || e == 4);
            ev = (e == 2 || e == 4) ? 8'hFF : 8'h00;
            wv = (e == 1 || e == 3) ? 8'hFF : 8'h00;
            for (int i = 0; i < int'(DEP); i++) begin
                a = dn ? int'(DEP) - 1 - i : i;
                if (e != 0) begin
                    v = fault_rd(m[a], a);
                    n++;
                    if (v !== ev) begin
                        p = 1'b0; fe = 3'(e); fa = 8'(a); fd = v; dc = n + 2;
                        return;
                    end
                end
                if (e != 5) begin
                    n++;
                    m[a] = wv;
                    if (f_kind == 3 && a == f_addr) m[f_vic] = m[f_vic] ^ f_mask;
                end
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic setup(input int k, input int fa, input int fv, input logic [7:0] m);
        f_kind = k; f_addr = fa; f_vic = fv; f_mask = m;
        for (int i = 0; i < int'(DEP); i++) mem_init[i] = 8'($urandom);
        @(negedge clk) init_req = 1'b1;
        @(negedge clk) init_req = 1'b0;
    endtask

    task automatic run_bist(output int dcyc, output int bcyc, output logic we_before);
        logic prev_we;
        dcyc = -1; bcyc = 0; we_before = 1'b1; prev_we = 1'b0;
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        for (int c = 1; c <= 1000; c++) begin
            if (bus.done) begin
                dcyc = c; we_before = prev_we;
                break;
            end
            if (bus.busy) bcyc++;
            prev_we = bus.ram_we;
            @(negedge clk);
        end
    endtask

    task automatic run_and_check(input string tag, input logic ep, input logic [2:0] ee,
                                 input logic [7:0] ea, input logic [7:0] ed, input int edone);
        int d, b;
        logic w;
        run_bist(d, b, w);
        chk({tag, ".done_cycle"}, 32'(d), 32'(edone));
        chk({tag, ".busy_cycles"}, 32'(b), 32'(edone - 1));
        chk({tag, ".we_before_done"}, 32'(w), 32'(0));
        chk({tag, ".pass"}, 32'(bus.pass), 32'(ep));
        chk({tag, ".fail_elem"}, 32'(bus.fail_elem), 32'(ee));
        chk({tag, ".fail_addr"}, 32'(bus.fail_addr), 32'(ea));
        chk({tag, ".fail_data"}, 32'(bus.fail_data), 32'(ed));
        @(negedge clk);
        chk({tag, ".done_one_cycle"}, 32'(bus.done), 32'(0));
        chk({tag, ".idle_busy"}, 32'(bus.busy), 32'(0));
    endtask

    initial begin
        logic       p;
        logic [2:0] e;
        logic [7:0] a, d;
        int         dc, k, fa, fv, ndone, first_done, nbusy_after, d1, b1;
        logic [7:0] m;

        rst = 1'b1; bus.start = 1'b0; bus1.start = 1'b0;
        f_kind = 0; f_addr = 0; f_vic = 0; f_mask = '0;
        vecs[0] = '{0, 0, 0, 8'h00, 1'b1, 3'd0, 8'd0, 8'h00, 642};
        vecs[1] = '{1, 5, 0, 8'h08, 1'b0, 3'd2, 8'd5, 8'hF7, 205};
        vecs[2] = '{2, 63, 0, 8'h01, 1'b0, 3'd1, 8'd63, 8'h01, 193};
        vecs[3] = '{3, 10, 11, 8'h80, 1'b0, 3'd1, 8'd11, 8'h80, 89};

        repeat (2) @(negedge clk);
        chk("rst.busy", 32'(bus.busy), 32'(0));
        chk("rst.done", 32'(bus.done), 32'(0));
        chk("rst.pass", 32'(bus.pass), 32'(0));
        chk("rst.ram_we", 32'(bus.ram_we), 32'(0));
        chk("rst.ram_addr", 32'(bus.ram_addr), 32'(0));
        chk("rst.ram_data", 32'(bus.ram_data), 32'(0));
        chk("rst.fail_addr", 32'(bus.fail_addr), 32'(0));
        chk("rst.fail_elem", 32'(bus.fail_elem), 32'(0));
        chk("rst.fail_data", 32'(bus.fail_data), 32'(0));
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            setup(vecs[i].kind, vecs[i].faddr, vecs[i].fvic, vecs[i].mask);
            run_and_check($sformatf("vec%0d", i), vecs[i].exp_pass, vecs[i].exp_elem,
                          vecs[i].exp_addr, vecs[i].exp_data, vecs[i].exp_done);
        end

        for (int t = 0; t < 8; t++) begin
            k  = int'($urandom_range(0, 3));
            fa = int'($urandom_range(0, 63));
            fv = (fa + int'($urandom_range(1, 63))) % 64;
            m  = 8'(1 << $urandom_range(0, 7));
            setup(k, fa, fv, m);
            ref_march(p, e, a, d, dc);
            run_and_check($sformatf("rand%0d_k%0d", t, k), p, e, a, d, dc);
        end

        // Asynchronous reset in the middle of E3 (cycle 350 is a write phase).
        setup(0, 0, 0, 8'h00);
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        repeat (349) @(negedge clk);
        chk("midrst.busy_before", 32'(bus.busy), 32'(1));
        chk("midrst.we_before", 32'(bus.ram_we), 32'(1));
        #1 rst = 1'b1;
        #1;
        chk("midrst.busy", 32'(bus.busy), 32'(0));
        chk("midrst.ram_we", 32'(bus.ram_we), 32'(0));
        chk("midrst.done", 32'(bus.done), 32'(0));
        chk("midrst.ram_addr", 32'(bus.ram_addr), 32'(0));
        @(negedge clk) rst = 1'b0;
        run_and_check("rerun", 1'b1, 3'd0, 8'd0, 8'h00, 642);

        // Repeated start during the run and in the DONE cycle.
        setup(0, 0, 0, 8'h00);
        ndone = 0; first_done = -1; nbusy_after = 0;
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        for (int c = 1; c <= 700; c++) begin
            if (bus.done) begin
                ndone++;
                if (first_done < 0) first_done = c;
            end
            if (c > 642 && bus.busy) nbusy_after++;
            bus.start = ((c % 50 == 0) && c < 640) || (c == 642);
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk("restart.done_count", 32'(ndone), 32'(1));
        chk("restart.done_cycle", 32'(first_done), 32'(642));
        chk("restart.busy_after", 32'(nbusy_after), 32'(0));
        chk("restart.pass", 32'(bus.pass), 32'(1));

        // Single-word array still runs every element.
        d1 = -1; b1 = 0;
        @(negedge clk) bus1.start = 1'b1;
        @(negedge clk) bus1.start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (bus1.done && d1 < 0) d1 = c;
            if (bus1.busy) b1++;
            @(negedge clk);
        end
        chk("depth1.done_cycle", 32'(d1), 32'(12));
        chk("depth1.busy_cycles", 32'(b1), 32'(11));
        chk("depth1.pass", 32'(bus1.pass), 32'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
